frame_irq: RTL and testbench

Frame timing and maskable-interrupt generator for the TS2068 core. It counts CPU T-states and produces the horizontal/vertical position and the once-per-frame active-low interrupt that drives the CPU's `irq` input. It sits directly upstream of the CPU and advances on the same `pe` clock enable the CPU uses. It also observes the CPU's `m1`/`iorq` outputs so it can optionally retire the interrupt on acknowledge.

---
 rtl/frame_irq.sv | 120 ++++++++++++
 tb/tb_frame_irq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_irq.sv
// frame_irq: T-state frame timing and active-low maskable interrupt generator.
// Counts CPU T-states (advancing on the pe enable) into a horizontal/vertical
// position, pulses frame once per frame and drives the CPU irq line low for a
// fixed window at the start of the interrupt line.
// Optional feature macro: IRQ_ACK_EN retires the interrupt when the CPU
// acknowledges it (m1=0 and iorq=0 while irq is low).
module frame_irq #(
   parameter int LINE_T      = 224,
   parameter int FRAME_LINES = 262,
   parameter int IRQ_LINE    = 0,
   parameter int IRQ_WIDTH   = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pe,
   input  logic       m1,
   input  logic       iorq,
   input  logic       irqdis,
   output logic       irq,
   output logic [8:0] hc,
   output logic [8:0] vc,
   output logic       frame
);

   localparam logic [8:0] LP_HC_LAST  = 9'(LINE_T - 1);
   localparam logic [8:0] LP_VC_LAST  = 9'(FRAME_LINES - 1);
   localparam logic [8:0] LP_IRQ_LINE = 9'(IRQ_LINE);
   // One extra bit so IRQ_WIDTH = 512 still compares correctly against hc.
   localparam logic [9:0] LP_IRQ_WIDTH = 10'(IRQ_WIDTH);

   logic [8:0] r_hc;
   logic [8:0] r_vc;
   logic       r_irq;
   logic       r_frame;

   logic [8:0] w_hc_next;
   logic [8:0] w_vc_next;
   logic       w_wrap;
   logic       w_win_cur;
   logic       w_win_next;
   logic       w_win_start;
   logic       w_ackd_next;

   // Next counter values: advance only on pe, wrap at line and frame ends.
   always_comb begin
      w_hc_next = r_hc;
      w_vc_next = r_vc;
      if (pe) begin
         if (r_hc == LP_HC_LAST) begin
            w_hc_next = 9'd0;
            w_vc_next = (r_vc == LP_VC_LAST) ? 9'd0 : r_vc + 9'd1;
         end else begin
            w_hc_next = r_hc + 9'd1;
         end
      end
   end

   // Window on the current and on the about-to-be-loaded position. Without pe
   // the next position equals the current one, so the window holds.
   assign w_win_cur   = (r_vc == LP_IRQ_LINE) && ({1'b0, r_hc} < LP_IRQ_WIDTH);
   assign w_win_next  = (w_vc_next == LP_IRQ_LINE) && ({1'b0, w_hc_next} < LP_IRQ_WIDTH);
   assign w_win_start = w_win_next && !w_win_cur;
   assign w_wrap      = pe && (r_hc == LP_HC_LAST) && (r_vc == LP_VC_LAST);

`ifdef IRQ_ACK_EN
   logic r_ackd;
   logic w_ack_det;

   // Acknowledge is only meaningful while the interrupt is actually asserted.
   assign w_ack_det = !m1 && !iorq && !r_irq;
   // A new window start wins over a coincident acknowledge so that the fresh
   // interrupt is never swallowed.
   assign w_ackd_next = w_win_start ? 1'b0 : (r_ackd || w_ack_det);

   // Acknowledge flag: set by the CPU ack, held until the next window start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ackd <= 1'b0;
      end else begin
         r_ackd <= w_ackd_next;
      end
   end
`else
   logic w_unused_ack;

   // Acknowledge is ignored in this build; the window always runs full length.
   assign w_ackd_next  = 1'b0;
   assign w_unused_ack = m1 & iorq & w_win_start;
`endif

   // Position counters and the one-clock frame pulse on the wrap to (0,0).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hc    <= 9'd0;
         r_vc    <= 9'd0;
         r_frame <= 1'b0;
      end else begin
         r_hc    <= w_hc_next;
         r_vc    <= w_vc_next;
         r_frame <= w_wrap;
      end
   end

   // Interrupt output: registered every clock so irqdis and ack act even
   // between T-state strobes; it uses the ack flag value being loaded so an
   // acknowledge releases irq on the detecting edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_irq <= 1'b1;
      end else begin
         r_irq <= !(w_win_next && !irqdis && !w_ackd_next);
      end
   end

   assign irq   = r_irq;
   assign hc    = r_hc;
   assign vc    = r_vc;
   assign frame = r_frame;

endmodule

// File: tb/tb_frame_irq.sv
// tb_frame_irq: directed bench for frame_irq with a reduced frame geometry
// (40 T-states x 5 lines, window of 32 on line 0) so several frames fit in a
// short run. Reference position is kept by the bench and advanced per strobe.
module tb_frame_irq;

  localparam int LT = 40;
  localparam int FL = 5;
  localparam int IL = 0;
  localparam int IW = 32;

  logic       clock;
  logic       reset;
  logic       pe;
  logic       m1;
  logic       iorq;
  logic       irqdis;
  logic       irq;
  logic [8:0] hc;
  logic [8:0] vc;
  logic       frame;

  int n_checks;
  int n_fail;

  // reference state
  int m_hc;
  int m_vc;
  bit m_ackd;
  bit count_en;
  int low_cnt;
  int frame_cnt;

  frame_irq #(
    .LINE_T(LT),
    .FRAME_LINES(FL),
    .IRQ_LINE(IL),
    .IRQ_WIDTH(IW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pe(pe),
    .m1(m1),
    .iorq(iorq),
    .irqdis(irqdis),
    .irq(irq),
    .hc(hc),
    .vc(vc),
    .frame(frame)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t pos=%0d,%0d)", tag, obs, exp, $time, m_vc, m_hc);
    end
  endtask

  function automatic int exp_irq();
    if (m_vc == IL && m_hc < IW && !irqdis && !m_ackd) return 0;
    return 1;
  endfunction

  // one clock with pe=1; outputs sampled 1 time unit after the edge
  task automatic pe_step();
    int exp_frame;
    pe = 1'b1;
    @(posedge clock);
    #1;
    pe = 1'b0;
    exp_frame = (m_hc == LT - 1 && m_vc == FL - 1) ? 1 : 0;
    if (m_hc == LT - 1) begin
      m_hc = 0;
      m_vc = (m_vc == FL - 1) ? 0 : m_vc + 1;
    end else begin
      m_hc = m_hc + 1;
    end
    if (m_hc == 0 && m_vc == IL) m_ackd = 1'b0;
    check("hc", int'(hc), m_hc);
    check("vc", int'(vc), m_vc);
    check("frame", int'(frame), exp_frame);
    check("irq", int'(irq), exp_irq());
    if (count_en) begin
      if (frame === 1'b1) begin
        if (frame_cnt > 0) check("irq_low_per_frame", low_cnt, IW);
        frame_cnt++;
        low_cnt = 0;
      end
      if (irq === 1'b0) low_cnt++;
    end
  endtask

  // clocks with pe=0: counters hold, frame stays low
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      check("hold_hc", int'(hc), m_hc);
      check("hold_vc", int'(vc), m_vc);
      check("hold_frame", int'(frame), 0);
      check("hold_irq", int'(irq), exp_irq());
    end
  endtask

  task automatic run_to(input int v, input int h);
    int guard;
    guard = 0;
    while (!(m_vc == v && m_hc == h) && guard < 1000) begin
      pe_step();
      guard++;
    end
    if (guard >= 1000) check("run_to_timeout", 0, 1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_hc      = 0;
    m_vc      = 0;
    m_ackd    = 1'b0;
    count_en  = 1'b0;
    low_cnt   = 0;
    frame_cnt = 0;
    reset  = 1'b1;
    pe     = 1'b0;
    m1     = 1'b1;
    iorq   = 1'b1;
    irqdis = 1'b0;

    // reset values while reset is held
    repeat (3) @(posedge clock);
    #1;
    check("rst_hc", int'(hc), 0);
    check("rst_vc", int'(vc), 0);
    check("rst_irq", int'(irq), 1);
    check("rst_frame", int'(frame), 0);
    @(negedge clock);
    reset = 1'b0;

    // first strobe after reset loads (0,1) with irq asserted
    pe_step();
    check("first_pe_hc", int'(hc), 1);
    check("first_pe_irq", int'(irq), 0);

    // free run, pe every 8th clock, three full frames
    count_en = 1'b1;
    for (int i = 1; i < 3 * LT * FL; i++) begin
      idle(7);
      pe_step();
    end
    count_en = 1'b0;
    check("frame_pulses", frame_cnt, 3);
    check("at_frame_start_hc", int'(hc), 0);
    check("at_frame_start_vc", int'(vc), 0);

    // irqdis raised at (0,10), released at (0,20)
    run_to(0, 10);
    check("pre_dis_irq", int'(irq), 0);
    irqdis = 1'b1;
    idle(1);
    check("dis_rise_irq", int'(irq), 1);
    run_to(0, 20);
    check("dis_held_irq", int'(irq), 1);
    irqdis = 1'b0;
    idle(1);
    check("dis_fall_irq", int'(irq), 0);
    run_to(0, 31);
    check("win_last_irq", int'(irq), 0);
    pe_step();
    check("win_end_irq", int'(irq), 1);

    // acknowledge cycle at (0,5) of the next frame
    run_to(0, 0);
    run_to(0, 5);
    m1   = 1'b0;
    iorq = 1'b0;
`ifdef IRQ_ACK_EN
    m_ackd = 1'b1;
    idle(1);
    check("ack_irq", int'(irq), 1);
`else
    idle(1);
    check("ack_ignored_irq", int'(irq), 0);
`endif
    m1   = 1'b1;
    iorq = 1'b1;
    run_to(0, 31);
`ifdef IRQ_ACK_EN
    check("ack_hold_irq", int'(irq), 1);
`else
    check("noack_hold_irq", int'(irq), 0);
`endif
    run_to(0, 0);
    check("next_frame_irq", int'(irq), 0);

    // asynchronous reset mid-window at (0,12)
    run_to(0, 12);
    check("pre_rst_irq", int'(irq), 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_irq", int'(irq), 1);
    check("async_rst_hc", int'(hc), 0);
    check("async_rst_vc", int'(vc), 0);
    check("async_rst_frame", int'(frame), 0);
    @(negedge clock);
    reset  = 1'b0;
    m_hc   = 0;
    m_vc   = 0;
    m_ackd = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < LT; i++) begin
      pe_step();
      if (i == 0) begin
        check("post_rst_hc", int'(hc), 1);
        check("post_rst_irq", int'(irq), 0);
      end
      if (irq === 1'b0) low_cnt++;
    end
    check("post_rst_low_strobes", low_cnt, IW - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "simulation time limit reached");
  end

endmodule
